// File: rtl/div_restoring.sv
// Iterative unsigned restoring divider: one quotient bit per clock, start/done handshake.
// Divide-by-zero completes in one cycle with saturated quotient and pass-through remainder.
//
// state | meaning
// IDLE  | waiting for start; results held
// RUN   | one restoring step per edge, count steps remaining
// DONE  | one-cycle done pulse, results valid
module div_restoring #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] part_rem;
  logic [WIDTH-1:0] quo_sh;
  logic [WIDTH-1:0] divisor_r;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  logic             borrow;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;
  logic             last_step;

  // Extra guard bit on the subtraction makes the borrow unambiguous even when
  // the shifted remainder uses its WIDTH+1'th bit.
  always_comb begin
    shifted   = {part_rem, quo_sh[WIDTH-1]};
    diff      = {1'b0, shifted} - {2'b00, divisor_r};
    borrow    = diff[WIDTH+1];
    rem_nx    = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    quo_nx    = {quo_sh[WIDTH-2:0], ~borrow};
    last_step = (count == CW'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nx = (divisor == '0) ? DONE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_step) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= '0;
      part_rem    <= '0;
      quo_sh      <= '0;
      divisor_r   <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              quo_sh    <= dividend;
              divisor_r <= divisor;
              part_rem  <= '0;
              count     <= CW'(WIDTH);
            end
          end
        end
        RUN: begin
          part_rem <= rem_nx;
          quo_sh   <= quo_nx;
          count    <= count - CW'(1);
          // Results are published on the final step so they appear with done.
          if (last_step) begin
            quotient    <= quo_nx;
            remainder   <= rem_nx;
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_restoring.sv
// Directed bench for div_restoring: hand-computed vectors, latency, ignored starts, reset abort.
module tb_div_restoring;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt = 0;
  int base_cnt = 0;

  div_restoring #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  function automatic void chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endfunction

  task automatic launch(input logic [31:0] dvd, input logic [31:0] dvs);
    @(negedge clk);
    dividend = dvd;
    divisor  = dvs;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 32'hDEAD_BEEF;
    divisor  = 32'h0000_0003;
    cyc      = 1;
  endtask

  task automatic wait_done();
    while (done !== 1'b1 && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic check_result(input string tag, input int exp_cyc, input logic [31:0] q,
                              input logic [31:0] r, input logic dbz);
    chk({tag, " done"}, {31'b0, done}, 32'd1);
    chk({tag, " latency"}, cyc, exp_cyc);
    chk({tag, " quotient"}, quotient, q);
    chk({tag, " remainder"}, remainder, r);
    chk({tag, " div_by_zero"}, {31'b0, div_by_zero}, {31'b0, dbz});
    chk({tag, " busy at done"}, {31'b0, busy}, 32'd0);
    @(posedge clk);
    #1;
    chk({tag, " done one cycle"}, {31'b0, done}, 32'd0);
    chk({tag, " quotient held"}, quotient, q);
    chk({tag, " remainder held"}, remainder, r);
  endtask

  initial begin
    #2;
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset done", {31'b0, done}, 32'd0);
    chk("reset quotient", quotient, 32'd0);
    chk("reset remainder", remainder, 32'd0);
    chk("reset dbz", {31'b0, div_by_zero}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 100 / 7
    launch(32'd100, 32'd7);
    chk("100/7 busy", {31'b0, busy}, 32'd1);
    wait_done();
    check_result("100/7", 33, 32'd14, 32'd2, 1'b0);

    launch(32'hFFFF_FFFF, 32'd1);
    wait_done();
    check_result("max/1", 33, 32'hFFFF_FFFF, 32'd0, 1'b0);

    launch(32'h8000_0000, 32'h4000_0000);
    wait_done();
    check_result("msb/2^30", 33, 32'd2, 32'd0, 1'b0);

    // 5 / 0 with start held into DONE carrying different operands
    @(negedge clk);
    dividend = 32'd5;
    divisor  = 32'd0;
    start    = 1'b1;
    @(posedge clk);
    #1;
    dividend = 32'd77;
    chk("5/0 done", {31'b0, done}, 32'd1);
    chk("5/0 quotient", quotient, 32'hFFFF_FFFF);
    chk("5/0 remainder", remainder, 32'd5);
    chk("5/0 dbz", {31'b0, div_by_zero}, 32'd1);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("5/0 start in DONE ignored done", {31'b0, done}, 32'd0);
    chk("5/0 start in DONE ignored busy", {31'b0, busy}, 32'd0);
    chk("5/0 remainder held", remainder, 32'd5);
    chk("5/0 dbz held", {31'b0, div_by_zero}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("5/0 no second done", {31'b0, done}, 32'd0);
    chk("5/0 remainder still held", remainder, 32'd5);

    launch(32'd3, 32'd10);
    wait_done();
    check_result("3/10", 33, 32'd0, 32'd3, 1'b0);

    launch(32'hFFFF_FFF0, 32'hFFFF_FFFF);
    wait_done();
    check_result("fff0/ffff", 33, 32'd0, 32'hFFFF_FFF0, 1'b0);

    launch(32'd0, 32'd9);
    wait_done();
    check_result("0/9", 33, 32'd0, 32'd0, 1'b0);

    // 1000 / 3 with a 9 / 2 request mid-run
    base_cnt = done_cnt;
    launch(32'd1000, 32'd3);
    for (int i = 0; i < 9; i++) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    start    = 1'b1;
    dividend = 32'd9;
    divisor  = 32'd2;
    @(posedge clk);
    #1;
    cyc++;
    start = 1'b0;
    chk("1000/3 busy mid-run", {31'b0, busy}, 32'd1);
    wait_done();
    check_result("1000/3", 33, 32'd333, 32'd1, 1'b0);
    repeat (40) @(posedge clk);
    #1;
    chk("1000/3 single done", done_cnt - base_cnt, 32'd1);

    // 1000 / 3 aborted by reset
    base_cnt = done_cnt;
    launch(32'd1000, 32'd3);
    for (int i = 0; i < 14; i++) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    chk("abort busy", {31'b0, busy}, 32'd0);
    chk("abort done", {31'b0, done}, 32'd0);
    chk("abort quotient", quotient, 32'd0);
    chk("abort remainder", remainder, 32'd0);
    chk("abort dbz", {31'b0, div_by_zero}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("abort no done", done_cnt - base_cnt, 32'd0);
    chk("abort idle", {31'b0, busy}, 32'd0);

    launch(32'd50, 32'd5);
    wait_done();
    check_result("50/5", 33, 32'd10, 32'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
